lat_event_reader: RTL

Synchronous reader on the far side of the team's transparent latch (`gate`/`aclr`/`aset`/`data`/`q`). It watches the latch's control lines and output `q`, turns every latch close, clear and set into a tagged event, and buffers events in a small FIFO. Events are drained through a valid/ready port. It sits between a latch bank and a clocked consumer (checker, logger, bus slave) that needs each value the latch held exactly once.

---
 rtl/lat_event_reader.sv | 92 +++++++++
 1 files changed

// File: rtl/lat_event_reader.sv
// Synchronous observer of a transparent latch: turns latch close/clear/set into
// tagged events and buffers them in a small FIFO drained over valid/ready.
module lat_event_reader #(
    parameter int LAT_WIDTH = 8,
    parameter int DEPTH     = 4,
    parameter int AW        = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 gate,
    input  logic                 aclr,
    input  logic                 aset,
    input  logic [LAT_WIDTH-1:0] q,
    output logic                 rd_valid,
    input  logic                 rd_ready,
    output logic [LAT_WIDTH-1:0] rd_data,
    output logic [1:0]           rd_tag,
    output logic [AW:0]          count,
    output logic                 overflow,
    input  logic                 ovf_clr
);

    localparam logic [1:0] TAG_CAPTURE = 2'b00;
    localparam logic [1:0] TAG_CLEAR   = 2'b01;
    localparam logic [1:0] TAG_SET     = 2'b10;
    localparam logic [AW:0] FULL_CNT   = (AW+1)'(DEPTH);

    logic                 gate_d, aclr_d, aset_d;
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [LAT_WIDTH-1:0] mem_data [DEPTH];
    logic [1:0]           mem_tag  [DEPTH];

    logic                 push_c, pop_c, accept_c, drop_c;
    logic [1:0]           push_tag_c;
    logic [LAT_WIDTH-1:0] push_data_c;

    // Event selection: CLEAR beats SET beats CAPTURE; losers vanish silently.
    always_comb begin
        push_c      = 1'b0;
        push_tag_c  = TAG_CAPTURE;
        push_data_c = '0;
        if (aclr && !aclr_d) begin
            push_c      = 1'b1;
            push_tag_c  = TAG_CLEAR;
        end else if (aset && !aset_d) begin
            push_c      = 1'b1;
            push_tag_c  = TAG_SET;
            push_data_c = '1;
        end else if (gate_d && !gate && !aclr && !aset) begin
            push_c      = 1'b1;
            push_data_c = q;
        end
    end

    assign rd_valid = (count != '0);
    assign pop_c    = rd_valid && rd_ready;
    assign accept_c = push_c && ((count != FULL_CNT) || pop_c);
    assign drop_c   = push_c && !accept_c;

    // Empty FIFO presents zeros so the head outputs stay stable while idle.
    assign rd_data = rd_valid ? mem_data[rd_ptr] : '0;
    assign rd_tag  = rd_valid ? mem_tag[rd_ptr]  : 2'b00;

    always_ff @(posedge clk) begin
        if (rst) begin
            gate_d   <= 1'b0;
            aclr_d   <= 1'b0;
            aset_d   <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            gate_d   <= gate;
            aclr_d   <= aclr;
            aset_d   <= aset;
            if (accept_c) wr_ptr <= AW'(wr_ptr + 1'b1);
            if (pop_c)    rd_ptr <= AW'(rd_ptr + 1'b1);
            count    <= (AW+1)'(count + (AW+1)'(accept_c) - (AW+1)'(pop_c));
            overflow <= drop_c || (overflow && !ovf_clr);
        end
    end

    // Storage is deliberately not reset; pointers and count define validity.
    always_ff @(posedge clk) begin
        if (accept_c && !rst) begin
            mem_data[wr_ptr] <= push_data_c;
            mem_tag[wr_ptr]  <= push_tag_c;
        end
    end

endmodule
